// File: rtl/ahb_lite_master_interface_if.sv
// Bundle of local request/response and AHB-Lite signals for the single-transfer master.
// The master modport is the bus initiator; the slave modport is the user/system side
// (local requester plus the AHB slave that answers it).
interface ahb_lite_master_interface_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_size;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_master_interface.sv
// Single-transfer AHB-Lite master. One NONSEQ/SINGLE transfer per local request,
// wait-state and two-cycle ERROR handling, local rejection of misaligned/oversized
// requests. Every output comes straight from a flop.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | no transfer outstanding, req_ready=1
//  ADDR   | NONSEQ address phase on the bus, waiting for HREADY
//  DATA   | data phase, waiting for HREADY (ERROR first cycle is just a wait)
//  LERR   | request rejected locally, error response pulsed, no bus activity
module ahb_lite_master_interface #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_lite_master_interface_if.master bus
);

  localparam int         MAX_SIZE      = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_LERR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  req_legal;

  // Request legality: size must fit the data bus and address must be size-aligned.
  always_comb begin
    align_mask = (ADDR_WIDTH'(1) << bus.req_size) - ADDR_WIDTH'(1);
    req_legal  = (bus.req_size <= 3'(MAX_SIZE)) && ((bus.req_addr & align_mask) == '0);
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= 3'b000;
      htrans_q     <= HTRANS_IDLE;
      hwdata_q     <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      htrans_q     <= htrans_d;
      hwdata_q     <= hwdata_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state and next-output decode; address-phase signals hold unless changed here.
  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    htrans_d     = htrans_q;
    hwdata_d     = hwdata_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      // LERR is the response cycle of a rejected request and accepts like IDLE,
      // so a rejection never costs the requester an extra cycle.
      S_IDLE, S_LERR: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          if (req_legal) begin
            state_d     = S_ADDR;
            htrans_d    = HTRANS_NONSEQ;
            haddr_d     = bus.req_addr;
            hwrite_d    = bus.req_write;
            hsize_d     = bus.req_size;
            wdata_d     = bus.req_wdata;
            req_ready_d = 1'b0;
          end else begin
            state_d      = S_LERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (bus.HREADY) begin
          state_d  = S_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      S_DATA: begin
        if (bus.HREADY) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = bus.HRESP;
          if (!hwrite_q && !bus.HRESP) begin
            resp_rdata_d = bus.HRDATA;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        htrans_d    = HTRANS_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.HADDR      = haddr_q;
  assign bus.HWRITE     = hwrite_q;
  assign bus.HSIZE      = hsize_q;
  assign bus.HBURST     = HBURST_SINGLE;
  assign bus.HPROT      = HPROT_VAL;
  assign bus.HTRANS     = htrans_q;
  assign bus.HWDATA     = hwdata_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_interface.sv
// Scoreboard bench for the AHB-Lite master: a memory-backed slave with wait states
// and an error region, a reference model filling expectation queues at request
// acceptance, and a monitor that checks bus transfers and responses.
module tb_ahb_lite_master_interface;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_lite_master_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  typedef struct {logic err; logic [31:0] rdata;} resp_t;
  typedef struct {logic [31:0] addr; logic write; logic [2:0] size; logic [31:0] wdata;} xfer_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int resp_seen = 0;
  int last_accept = 0;
  resp_t resp_q[$];
  xfer_t bus_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  bit rand_mode = 0;
  int fixed_wait = 0;

  always @(posedge HCLK) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fill_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // AHB slave: decides HREADY/HRESP/HRDATA for each cycle at the falling edge.
  initial begin
    bit dp_act = 0, dp_write = 0, dp_err = 0, err_stage = 0, done, start;
    logic [31:0] dp_addr = '0;
    int wait_left = 0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_act = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        continue;
      end
      done = 0;
      bus.HRDATA = $urandom;
      if (dp_act) begin
        if (dp_err) begin
          bus.HRESP = 1'b1;
          if (!err_stage) begin bus.HREADY = 1'b0; err_stage = 1; end
          else begin bus.HREADY = 1'b1; done = 1; end
        end else if (wait_left > 0) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b0; wait_left--;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = 1'b0; done = 1;
          if (dp_write) slv_mem[dp_addr] = bus.HWDATA;
          else bus.HRDATA = slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : fill_val(dp_addr);
        end
      end else begin
        bus.HRESP  = 1'b0;
        bus.HREADY = (rand_mode && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      end
      start = (bus.HTRANS == 2'b10) && bus.HREADY;
      if (done) dp_act = 0;
      if (start) begin
        dp_act = 1; dp_addr = bus.HADDR; dp_write = bus.HWRITE;
        dp_err = (bus.HADDR[15:12] == 4'hE); err_stage = 0;
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : fixed_wait;
      end
    end
  end

  // Monitor: bus transfers against the expected-transfer queue, responses against the scoreboard.
  initial begin
    bit mon_dp = 0;
    xfer_t mx, cur;
    resp_t r;
    forever begin
      @(negedge HCLK);
      #2;
      if (!HRESETn) begin mon_dp = 0; continue; end
      if (bus.resp_valid) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=resp_valid expected=none");
        end else begin
          r = resp_q.pop_front();
          chk("resp_err", bus.resp_err, r.err);
          chk("resp_rdata", bus.resp_rdata, r.rdata);
        end
      end
      if (mon_dp) begin
        if (cur.write) chk("hwdata", bus.HWDATA, cur.wdata);
        if (bus.HREADY) mon_dp = 0;
      end
      if (bus.HTRANS != 2'b00) begin
        chk("htrans_nonseq", bus.HTRANS, 2'b10);
        chk("hburst", bus.HBURST, 3'b000);
        chk("hprot", bus.HPROT, 4'b0011);
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer actual=0x%0h expected=none", bus.HADDR);
        end else begin
          mx = bus_q[0];
          chk("haddr", bus.HADDR, mx.addr);
          chk("hwrite", bus.HWRITE, mx.write);
          chk("hsize", bus.HSIZE, mx.size);
          if (bus.HREADY) begin
            cur = bus_q.pop_front();
            mon_dp = 1;
          end
        end
      end
    end
  end

  // Present a request and hold it until accepted; the reference model records the
  // expected outcome at acceptance. Returns at the falling edge after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    bit ok = 0;
    bit legal;
    resp_t r;
    xfer_t x;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_size = s; bus.req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin ok = 1; break; end
      @(negedge HCLK);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_ready expected=ready");
      bus.req_valid = 1'b0;
      return;
    end
    last_accept = cycle;
    legal = (s <= 3'd2) && ((a % (32'd1 << s)) == 0);
    r.err = 1'b0; r.rdata = '0;
    if (!legal || a[15:12] == 4'hE) r.err = 1'b1;
    else if (w) ref_mem[a] = d;
    else r.rdata = ref_mem.exists(a) ? ref_mem[a] : fill_val(a);
    if (legal) begin
      x.addr = a; x.write = w; x.size = s; x.wdata = d;
      bus_q.push_back(x);
    end
    resp_q.push_back(r);
    @(negedge HCLK);
  endtask

  // Single request with latency measured from acceptance to resp_valid.
  task automatic dir_test(input string nm, input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d, input int exp_lat, input logic [1:0] exp_htrans1);
    int lat = 1;
    issue(w, a, s, d);
    bus.req_valid = 1'b0;
    #2;
    chk({nm, "_htrans1"}, bus.HTRANS, exp_htrans1);
    while (!bus.resp_valid && lat < 60) begin
      @(negedge HCLK); #2;
      lat++;
      if (lat == 2 && w && exp_htrans1 == 2'b10) begin
        chk({nm, "_hwdata"}, bus.HWDATA, d);
        chk({nm, "_htrans2"}, bus.HTRANS, 2'b00);
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    @(negedge HCLK); #2;
    chk({nm, "_pulse"}, bus.resp_valid, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && resp_q.size() != 0; i++) @(negedge HCLK);
    chk("drain", resp_q.size(), 0);
  endtask

  initial begin
    int acc[4];
    int seen0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_wdata = '0;
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_hprot", bus.HPROT, 4'b0011);
    chk("rst_hburst", bus.HBURST, 3'b000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    slv_mem[32'h2004] = 32'h1234_5678;
    ref_mem[32'h2004] = 32'h1234_5678;

    fixed_wait = 0;
    dir_test("wr_zero_wait", 1'b1, 32'h1000, 3'd2, 32'hDEAD_BEEF, 3, 2'b10);
    fixed_wait = 3;
    dir_test("rd_wait3", 1'b0, 32'h2004, 3'd2, 32'h0, 6, 2'b10);
    fixed_wait = 0;
    dir_test("rd_error", 1'b0, 32'hE000, 3'd2, 32'h0, 4, 2'b10);
    dir_test("lerr_misalign", 1'b0, 32'h1002, 3'd2, 32'h0, 1, 2'b00);
    dir_test("lerr_size", 1'b1, 32'h1000, 3'd3, 32'h1111_2222, 1, 2'b00);
    dir_test("rd_back", 1'b0, 32'h1000, 3'd2, 32'h0, 3, 2'b10);

    seen0 = resp_seen;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h3000 + 32'(i * 4), 3'd2, $urandom);
      acc[i] = last_accept;
    end
    bus.req_valid = 1'b0;
    drain();
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
    chk("b2b_resp_count", resp_seen - seen0, 4);

    fixed_wait = 10;
    issue(1'b0, 32'h2004, 3'd2, 32'h0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", bus.HTRANS, 2'b00);
    chk("arst_req_ready", bus.req_ready, 1'b1);
    chk("arst_resp_valid", bus.resp_valid, 1'b0);
    resp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    seen0 = resp_seen;
    repeat (15) @(negedge HCLK);
    chk("arst_no_resp", resp_seen - seen0, 0);
    fixed_wait = 0;

    rand_mode = 1;
    for (int n = 0; n < 250; n++) begin
      logic [31:0] base;
      case ($urandom_range(0, 2))
        0: base = 32'h1000;
        1: base = 32'h2000;
        default: base = 32'hE000;
      endcase
      repeat ($urandom_range(0, 2)) begin
        bus.req_valid = 1'b0;
        @(negedge HCLK);
      end
      issue(1'($urandom_range(0, 1)), base + 32'($urandom_range(0, 15)),
            3'($urandom_range(0, 4)), $urandom);
    end
    bus.req_valid = 1'b0;
    drain();
    rand_mode = 0;
    repeat (4) @(negedge HCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
